// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice built from two half
// adders is time-shared across WIDTH bits, LSB first, with valid/ready on both sides.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res, res_next;
  logic [CW-1:0]    cnt;
  logic             carry, carry_next, last;
  logic             s1, c1, s2, c2;

  half_adder u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1),      .b(carry),   .s(s2), .c(c2));

  assign carry_next = c1 | c2;
  assign last       = (cnt == CW'(WIDTH - 1));

  // Shift-right with the new bit entering at the MSB; written this way so WIDTH=1 works.
  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = s2;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= in_a;
          b_sr  <= op_sub ? ~in_b : in_b;
          carry <= op_sub;
          cnt   <= '0;
          res   <= '0;
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= carry_next;
          res   <= res_next;
          cnt   <= cnt + CW'(1);
          // Output word is only updated on the final bit so it holds through IDLE.
          if (last) begin
            sum       <= res_next;
            carry_out <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

endmodule
